// File: rtl/calc_result_display.sv
// rtl/calc_result_display.sv - captures a calculator result, converts it to BCD by shift-add-3 and scans it onto a 4-digit 7-segment display; optional two's-complement input via CALC_DISPLAY_SIGNED_EN
module calc_result_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  res_in,
    input  logic        res_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        neg,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nx;
    logic [7:0]    mag;
    logic [11:0]   scratch;
    logic [11:0]   scratch_adj;
    logic [2:0]    shift_cnt;
    logic          sign_lat;
    logic [7:0]    mag_in;
    logic          sign_in;

    logic [CW-1:0] ref_cnt;
    logic [1:0]    digit;
    logic [1:0]    digit_nx;
    logic [6:0]    seg_nx;
    logic [3:0]    an_nx;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Magnitude and sign of the incoming result
    always_comb begin
`ifdef CALC_DISPLAY_SIGNED_EN
        sign_in = res_in[7];
        mag_in  = res_in[7] ? (~res_in + 8'd1) : res_in;
`else
        sign_in = 1'b0;
        mag_in  = res_in;
`endif
    end

    // Add-3 correction on every scratch nibble that would overflow past 9 after doubling
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Conversion FSM next-state: strobes outside IDLE are simply not looked at
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (res_valid) state_nx = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Conversion datapath: capture, eight shift-add-3 steps, then publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag       <= 8'd0;
            scratch   <= 12'd0;
            shift_cnt <= 3'd0;
            sign_lat  <= 1'b0;
            bcd       <= 12'd0;
            neg       <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        mag       <= mag_in;
                        sign_lat  <= sign_in;
                        scratch   <= 12'd0;
                        shift_cnt <= 3'd0;
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= {scratch_adj, mag} << 1;
                    shift_cnt      <= shift_cnt + 3'd1;
                end
                DONE: begin
                    bcd       <= scratch;
                    neg       <= sign_lat;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Decode of the slot about to be entered, with leading-zero blanking
    always_comb begin
        digit_nx = digit + 2'd1;
        seg_nx   = SEG_BLANK;
        an_nx    = 4'b1111;
        case (digit_nx)
            2'd0: begin
                an_nx  = 4'b1110;
                seg_nx = seg_of(bcd[3:0]);
            end
            2'd1: begin
                an_nx  = 4'b1101;
                seg_nx = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_of(bcd[7:4]);
            end
            2'd2: begin
                an_nx  = 4'b1011;
                seg_nx = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_of(bcd[11:8]);
            end
            default: begin
                an_nx  = neg ? 4'b0111 : 4'b1111;
                seg_nx = neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    // Free-running scanner; outputs only change on a slot boundary so a new bcd never glitches a slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            digit   <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            digit   <= digit_nx;
            an      <= an_nx;
            seg     <= seg_nx;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
// tb/tb_calc_result_display.sv - directed self-checking bench for calc_result_display
module tb_calc_result_display;

    localparam int RDIV = 4;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010, S9 = 7'b0010000, SB = 7'b1111111, SM = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  res_in;
    logic        res_valid;
    logic        busy;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        neg;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses = 0;

    calc_result_display #(.REFRESH_DIV(RDIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .res_valid (res_valid),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .neg       (neg),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bcd_valid) pulses++;
    endtask

    task automatic strobe(input logic [7:0] v);
        res_in    = v;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_busy", busy, 1'b0);
        chk("rst_bcd", bcd, 12'h000);
        chk("rst_bcd_valid", bcd_valid, 1'b0);
        chk("rst_neg", neg, 1'b0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
    endtask

    task automatic check_frame(input logic [15:0] ea, input logic [27:0] es, input logic sign_seg);
        while (cyc % (4 * RDIV) != 0) tick();
        for (int j = 0; j < 4 * RDIV; j++) begin
            int s;
            s = j / RDIV;
            chk("frame_an", an, ea[s*4 +: 4]);
            if (s != 3 || sign_seg)
                chk("frame_seg", seg, es[s*7 +: 7]);
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        res_in    = 8'd0;
        res_valid = 1'b0;
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        pulses = 0;
        strobe(8'd130);
        chk("e0_busy", busy, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("shift_busy", busy, 1'b1);
            chk("shift_no_valid", bcd_valid, 1'b0);
        end
        tick();
        chk("e9_busy", busy, 1'b0);
        chk("e9_valid", bcd_valid, 1'b1);
        chk("e9_bcd130", bcd, 12'h130);
        tick();
        chk("e10_valid", bcd_valid, 1'b0);
        chk("pulses130", pulses, 1);
        check_frame({4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SB, S1, S3, S0}, 1'b0);

        pulses = 0;
        strobe(8'd255);
        for (int i = 0; i < 9; i++) tick();
        chk("bcd255", bcd, 12'h255);
        chk("pulses255", pulses, 1);
        check_frame({4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SB, S2, S5, S5}, 1'b0);

        pulses = 0;
        strobe(8'd23);
        tick();
        tick();
        strobe(8'd7);
        chk("busy_at_e3", busy, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        chk("bcd023", bcd, 12'h023);
        chk("pulses023", pulses, 1);
        chk("idle_after_023", busy, 1'b0);
        check_frame({4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SB, SB, S2, S3}, 1'b0);

        pulses = 0;
        strobe(8'd200);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_pulses", pulses, 0);
        chk("abort_bcd", bcd, 12'h000);
        strobe(8'd9);
        for (int i = 0; i < 9; i++) tick();
        chk("bcd009", bcd, 12'h009);
        chk("pulses009", pulses, 1);
        check_frame({4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SB, SB, SB, S9}, 1'b0);

        pulses = 0;
        strobe(8'hFD);
        for (int i = 0; i < 9; i++) tick();
`ifdef CALC_DISPLAY_SIGNED_EN
        chk("bcd_fd", bcd, 12'h003);
        chk("neg_fd", neg, 1'b1);
        check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SM, SB, SB, S3}, 1'b1);
`else
        chk("bcd_fd", bcd, 12'h253);
        chk("neg_fd", neg, 1'b0);
        check_frame({4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SB, S2, S5, S3}, 1'b0);
`endif
        chk("pulses_fd", pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
